// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle CPU: sequences the shared ALU, memory port and register file,
// with a memory wait-state handshake, a memory timeout and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_src,
    output logic             ir_we,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LD_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                is_mem;
    logic                set_illegal;
    logic                set_timeout;
    logic                retire;

    // Next-state logic, including the memory timeout escape to HALT
    always_comb begin
        state_next  = state;
        is_mem      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_FETCH: begin
                is_mem = 1'b1;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                is_mem = 1'b1;
                if (mem_ready) state_next = S_LD_WB;
            end
            S_LD_WB:  state_next = S_FETCH;
            S_MEM_WR: begin
                is_mem = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R: state_next = S_R_WB;
            S_R_WB:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
        // A ready on the final wait cycle still completes the access
        if (is_mem && !mem_ready && TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
            state_next  = S_HALT;
            set_timeout = 1'b1;
        end
    end

    assign retire = (state_next == S_FETCH) && (state != S_FETCH);

    // State, wait counter, sticky faults and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (is_mem && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            illegal <= illegal | set_illegal;
            timeout <= timeout | set_timeout;
            retired <= retired + CNT_W'(retire);
        end
    end

    // Moore output decode; only FETCH and BRANCH look at an input
    always_comb begin
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_LD_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_R_WB: reg_we = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_we     = zero;
            end
            default: ;
        endcase
    end

    assign state_dbg = 4'(state);

endmodule
